// File: rtl/key_load_capture.sv
// Debounced push-button loader: on each confirmed press, latches the synchronized
// switch word into a held register that feeds the A operand and hex display chain.
module key_load_capture #(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 8
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  input  logic             key_n,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] data_out,
  output logic             load_pulse,
  output logic             pressed,
  output logic [CNT_W-1:0] load_count
);

  // state        | meaning
  // IDLE         | button released and stable, waiting for key_s low
  // PRESS_WAIT   | key_s low, counting stable cycles before accepting the press
  // PRESSED      | press accepted and captured, waiting for key_s high
  // RELEASE_WAIT | key_s high, counting stable cycles before accepting the release
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  localparam int              DB_W     = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [DB_W-1:0]  cnt_q, cnt_d;
  logic             key_meta_q, key_s_q;
  logic [WIDTH-1:0] sw_meta_q, sw_s_q;
  logic [WIDTH-1:0] data_q;
  logic             pulse_q;
  logic             pressed_q;
  logic [CNT_W-1:0] count_q;
  logic             capture;

  // Key chain resets to the released level so reset never looks like a press.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      key_meta_q <= 1'b1;
      key_s_q    <= 1'b1;
      sw_meta_q  <= '0;
      sw_s_q     <= '0;
    end else begin
      key_meta_q <= key_n;
      key_s_q    <= key_meta_q;
      sw_meta_q  <= sw_in;
      sw_s_q     <= sw_meta_q;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (!key_s_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (key_s_q) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          capture = 1'b1;
        end else begin
          cnt_d = cnt_q + DB_W'(1);
        end
      end
      PRESSED: begin
        if (key_s_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        // A low sample here is release bounce, never a fresh press.
        if (!key_s_q) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + DB_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      data_q    <= '0;
      pulse_q   <= 1'b0;
      pressed_q <= 1'b0;
      count_q   <= '0;
    end else begin
      pulse_q   <= capture;
      pressed_q <= (state_d == PRESSED) || (state_d == RELEASE_WAIT);
      if (capture) begin
        data_q  <= sw_s_q;
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  assign data_out   = data_q;
  assign load_pulse = pulse_q;
  assign pressed    = pressed_q;
  assign load_count = count_q;

endmodule

// File: tb/tb_key_load_capture.sv
// Bench for key_load_capture: directed table, corner sequences and random bouncing
// key stimulus against a run-length debounce model.
module tb_key_load_capture;

  localparam int DB = 4;

  logic        CLOCK_50;
  logic        RESET_N;
  logic        key_n;
  logic [15:0] sw_in;
  logic [15:0] data_out, data_out2;
  logic        load_pulse, load_pulse2;
  logic        pressed, pressed2;
  logic [7:0]  load_count;
  logic [1:0]  load_count2;

  int checks = 0;
  int errors = 0;

  key_load_capture #(.WIDTH(16), .DEBOUNCE_CYCLES(DB), .CNT_W(8)) u_dut (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .key_n(key_n), .sw_in(sw_in),
    .data_out(data_out), .load_pulse(load_pulse), .pressed(pressed), .load_count(load_count)
  );

  key_load_capture #(.WIDTH(16), .DEBOUNCE_CYCLES(DB), .CNT_W(2)) u_dut2 (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .key_n(key_n), .sw_in(sw_in),
    .data_out(data_out2), .load_pulse(load_pulse2), .pressed(pressed2), .load_count(load_count2)
  );

  initial begin
    CLOCK_50 = 1'b0;
    forever #5 CLOCK_50 = ~CLOCK_50;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Reference: inputs reach the decision two edges late; the debounced level flips
  // once the opposite level has been seen on DB+1 consecutive edges.
  logic        key_hist[$];
  logic [15:0] sw_hist[$];
  bit          m_level;
  int          m_run;
  bit          m_pulse;
  logic [15:0] m_data;
  logic [7:0]  m_count;

  task automatic model_reset();
    key_hist = {1'b1, 1'b1};
    sw_hist  = {16'h0, 16'h0};
    m_level  = 0;
    m_run    = 0;
    m_pulse  = 0;
    m_data   = 16'h0;
    m_count  = 8'h0;
  endtask

  task automatic model_edge(input logic k, input logic [15:0] s);
    logic        ks;
    logic [15:0] ss;
    bit          want;
    ks = key_hist.pop_front();
    ss = sw_hist.pop_front();
    key_hist.push_back(k);
    sw_hist.push_back(s);
    want    = !ks;
    m_pulse = 0;
    if (want != m_level) m_run++;
    else m_run = 0;
    if (m_run == DB + 1) begin
      m_level = want;
      m_run   = 0;
      if (want) begin
        m_data  = ss;
        m_count = m_count + 8'd1;
        m_pulse = 1;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic compare_model();
    check("data_out", 32'(data_out), 32'(m_data));
    check("load_pulse", 32'(load_pulse), 32'(m_pulse));
    check("pressed", 32'(pressed), 32'(m_level));
    check("load_count", 32'(load_count), 32'(m_count));
    check("data_out2", 32'(data_out2), 32'(m_data));
    check("load_count2", 32'(load_count2), 32'(m_count[1:0]));
  endtask

  // Called at a negedge; drives inputs, takes one rising edge, checks at the next negedge.
  task automatic cycle(input logic k, input logic [15:0] s);
    key_n = k;
    sw_in = s;
    @(posedge CLOCK_50);
    model_edge(k, s);
    @(negedge CLOCK_50);
    compare_model();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"}, 32'(data_out), 32'h0);
    check({tag, "_pulse"}, 32'(load_pulse), 32'h0);
    check({tag, "_pressed"}, 32'(pressed), 32'h0);
    check({tag, "_count"}, 32'(load_count), 32'h0);
    check({tag, "_count2"}, 32'(load_count2), 32'h0);
  endtask

  // Asserted between edges: outputs must clear without a clock edge.
  task automatic do_reset();
    #2;
    RESET_N = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    @(negedge CLOCK_50);
    RESET_N = 1'b1;
  endtask

  typedef struct {
    logic        key;
    logic [15:0] sw;
    int          hold;
    logic [15:0] exp_data;
    logic [7:0]  exp_count;
    logic        exp_pressed;
  } vec_t;

  vec_t vecs[8];
  int   pulses;
  logic [1:0] wrap_exp[5];

  initial begin
    vecs[0] = '{key: 1'b1, sw: 16'hA5C3, hold: 4,  exp_data: 16'h0000, exp_count: 8'd0, exp_pressed: 1'b0};
    vecs[1] = '{key: 1'b0, sw: 16'hA5C3, hold: 20, exp_data: 16'hA5C3, exp_count: 8'd1, exp_pressed: 1'b1};
    vecs[2] = '{key: 1'b1, sw: 16'hA5C3, hold: 10, exp_data: 16'hA5C3, exp_count: 8'd1, exp_pressed: 1'b0};
    vecs[3] = '{key: 1'b0, sw: 16'h00FF, hold: 20, exp_data: 16'h00FF, exp_count: 8'd2, exp_pressed: 1'b1};
    vecs[4] = '{key: 1'b0, sw: 16'h1234, hold: 10, exp_data: 16'h00FF, exp_count: 8'd2, exp_pressed: 1'b1};
    vecs[5] = '{key: 1'b1, sw: 16'h1234, hold: 10, exp_data: 16'h00FF, exp_count: 8'd2, exp_pressed: 1'b0};
    vecs[6] = '{key: 1'b0, sw: 16'h1234, hold: 20, exp_data: 16'h1234, exp_count: 8'd3, exp_pressed: 1'b1};
    vecs[7] = '{key: 1'b1, sw: 16'hFFFF, hold: 10, exp_data: 16'h1234, exp_count: 8'd3, exp_pressed: 1'b0};
    wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    RESET_N = 1'b0;
    key_n   = 1'b1;
    sw_in   = 16'h0;
    model_reset();
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    check_all_zero("reset");
    RESET_N = 1'b1;

    for (int v = 0; v < 8; v++) begin
      repeat (vecs[v].hold) cycle(vecs[v].key, vecs[v].sw);
      check($sformatf("vec%0d_data", v), 32'(data_out), 32'(vecs[v].exp_data));
      check($sformatf("vec%0d_count", v), 32'(load_count), 32'(vecs[v].exp_count));
      check($sformatf("vec%0d_pressed", v), 32'(pressed), 32'(vecs[v].exp_pressed));
    end

    // Clean press: pulse exactly on edge e0+6.
    repeat (3) cycle(1'b1, 16'hA5C3);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 16'hA5C3);
      check($sformatf("clean_pulse_e%0d", i), 32'(load_pulse), 32'(i == 6));
      check($sformatf("clean_pressed_e%0d", i), 32'(pressed), 32'(i >= 6));
    end
    check("clean_data", 32'(data_out), 32'hA5C3);
    check("clean_count", 32'(load_count), 32'd4);

    // Release bounce: no new capture, pressed falls after DB+1 stable high samples.
    pulses = 0;
    for (int r = 0; r < 2; r++) begin
      repeat (2) begin cycle(1'b1, 16'h5555); pulses += int'(load_pulse); check("relb_pressed_hold", 32'(pressed), 32'd1); end
      repeat (2) begin cycle(1'b0, 16'h5555); pulses += int'(load_pulse); check("relb_pressed_hold", 32'(pressed), 32'd1); end
    end
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 16'h5555);
      pulses += int'(load_pulse);
      check($sformatf("relb_pressed_e%0d", i), 32'(pressed), 32'(i < 6));
    end
    check("relb_pulses", 32'(pulses), 32'd0);
    check("relb_count", 32'(load_count), 32'd4);

    // Press bounce from reset: never reaches a capture.
    do_reset();
    pulses = 0;
    repeat (3)  begin cycle(1'b0, 16'hBEEF); pulses += int'(load_pulse); end
    repeat (1)  begin cycle(1'b1, 16'hBEEF); pulses += int'(load_pulse); end
    repeat (2)  begin cycle(1'b0, 16'hBEEF); pulses += int'(load_pulse); end
    repeat (10) begin cycle(1'b1, 16'hBEEF); pulses += int'(load_pulse); end
    check("pressb_pulses", 32'(pulses), 32'd0);
    check("pressb_data", 32'(data_out), 32'h0);
    check("pressb_count", 32'(load_count), 32'd0);
    check("pressb_pressed", 32'(pressed), 32'd0);

    // Counter wrap on the 2-bit instance.
    for (int p = 0; p < 5; p++) begin
      repeat (12) cycle(1'b0, 16'h1111 * 16'(p + 1));
      check($sformatf("wrap_count2_p%0d", p), 32'(load_count2), 32'(wrap_exp[p]));
      repeat (10) cycle(1'b1, 16'h1111 * 16'(p + 1));
    end
    check("wrap_count8", 32'(load_count), 32'd5);

    // Reset mid PRESS_WAIT with key still low, then a full new debounce.
    repeat (5) cycle(1'b0, 16'hC0DE);
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 16'hC0DE);
      check($sformatf("rst_pulse_e%0d", i), 32'(load_pulse), 32'(i == 6));
    end
    check("rst_count", 32'(load_count), 32'd1);
    check("rst_data", 32'(data_out), 32'hC0DE);
    repeat (10) cycle(1'b1, 16'hC0DE);

    // Random bouncy key with live switches.
    begin
      int n;
      n = 0;
      while (n < 3000) begin
        logic k;
        int   len;
        k   = 1'($urandom_range(0, 1));
        len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(6, 14)) : int'($urandom_range(1, 5));
        repeat (len) begin
          cycle(k, 16'($urandom));
          n++;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_load_capture.md
Name: key_load_capture

Overview:
- Upstream input stage for the switch-to-display datapath.
- Debounces a raw active-low push button (KEY[3] at top level).
- On each confirmed press, captures the synchronized switch bank SW[15:0] into a held register. That register drives the A operand of the bit-count/excess-3 stage and the hex display chain.
- Gives the display chain "load on key press" behaviour instead of a live switch view.

Parameters:
- WIDTH, 16, width of captured switch word.
- DEBOUNCE_CYCLES, 1000000, consecutive stable clocks required to accept a press or release (20 ms at 50 MHz). Legal minimum is 2.
- CNT_W, 8, width of the load counter.

Ports:
- CLOCK_50  input  1  system clock, 50 MHz, rising-edge.
- RESET_N  input  1  asynchronous active-low reset.
- key_n  input  1  raw push button: 0 = pressed. Asynchronous and bouncy.
- sw_in  input  WIDTH  raw slide switches. Asynchronous.
- data_out  output  WIDTH  last captured switch word. Feeds the A operand downstream.
- load_pulse  output  1  one-cycle strobe in the same cycle data_out first shows a new capture.
- pressed  output  1  debounced button level: 1 = held.
- load_count  output  CNT_W  number of captures since reset. Wraps modulo 2^CNT_W.

Behaviour:
- Reset and clocking:
  - One clock: CLOCK_50. Reset is asynchronous and active-low (RESET_N). While RESET_N = 0, all state clears immediately.
  - Reset values: data_out = 0, load_pulse = 0, pressed = 0, load_count = 0, FSM = IDLE, debounce counter = 0.
  - Synchronizer flops reset to the idle level: key chain to 1, sw chain to 0.
- Synchronization:
  - key_n passes through 2 flops, giving key_s.
  - sw_in passes through 2 flops, giving sw_s.
  - No raw input reaches the FSM or data_out directly.
- Debounce counter width is ceil(log2(DEBOUNCE_CYCLES)).
- FSM, 4 states:
  - IDLE: key_s = 0 → PRESS_WAIT, cnt = 0.
  - PRESS_WAIT:
    - key_s = 1 → IDLE (bounce rejected, no capture).
    - Otherwise, if cnt = DEBOUNCE_CYCLES-1 → PRESSED and capture. Else cnt + 1.
  - PRESSED: key_s = 1 → RELEASE_WAIT, cnt = 0.
  - RELEASE_WAIT:
    - key_s = 0 → PRESSED. No new capture; a release bounce is never a new press.
    - Otherwise, if cnt = DEBOUNCE_CYCLES-1 → IDLE. Else cnt + 1.
- Capture, on the PRESS_WAIT → PRESSED edge only:
  - data_out <= sw_s.
  - load_pulse = 1 for exactly one cycle.
  - load_count + 1, wrapping from all-ones to 0.
- pressed = 1 in PRESSED and RELEASE_WAIT, otherwise 0. Registered, and rises in the same cycle as load_pulse.
- Latency:
  - key_n held low from before rising edge e0 gives load_pulse high after edge e0 + DEBOUNCE_CYCLES + 2 (2 sync stages + IDLE sample + DEBOUNCE_CYCLES).
  - data_out reflects sw_in as sampled 2 edges before the capture edge.
- data_out holds between captures regardless of sw_in activity.
- Holding the key indefinitely produces exactly one capture.
- Reset mid-debounce or mid-hold returns to IDLE with no capture. A key still held low after reset release needs a full new debounce and then captures once.
- No X propagation: unused counter bits stay in a defined state, and the default FSM branch goes to IDLE.

Test Plan (DEBOUNCE_CYCLES = 4 unless noted):
- Clean press: sw_in = 16'hA5C3, then key_n 1→0 held 20 cycles → load_pulse high exactly 1 cycle at e0+6, data_out = 16'hA5C3, load_count = 1, pressed = 1 until the debounced release.
- Press bounce: key_n low 3 cycles, high 1, low 2, high → no load_pulse, data_out = 0, load_count = 0, FSM back in IDLE.
- Release bounce: after a valid press, key_n 0→1→0→1 with high intervals of 2 cycles, then high 10 → no second load_pulse, load_count = 1, pressed falls only after 4 stable high cycles.
- Hold-off: press captures 16'h00FF, sw_in changes to 16'h1234 while held → data_out stays 16'h00FF. Release plus second press → data_out = 16'h1234, load_count = 2.
- Wrap: CNT_W = 2, 5 valid presses → load_count sequence 1, 2, 3, 0, 1.
- Async reset: assert RESET_N = 0 mid-PRESS_WAIT (cnt = 2) without any clock edge → all outputs 0 immediately. Release with key_n still low → capture after a full 6-edge latency, load_count = 1.
